interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 18 +
 rtl/interrupt_controller_priority_enc.sv | 24 ++
 rtl/interrupt_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared types and defaults for the interrupt controller: FSM state encoding,
// default vector constants and the width of the in-service IRQ index.
package interrupt_controller_pkg;

   localparam int unsigned IC_ID_W       = 5;
   localparam logic [31:0] IC_NMI_VEC    = 32'h14;
   localparam logic [31:0] IC_VEC_BASE   = 32'h40;
   localparam int unsigned IC_VEC_STRIDE = 16;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_PEND        = 3'd1,
      ST_TAKE        = 3'd2,
      ST_SERVICE     = 3'd3,
      ST_NMI_SERVICE = 3'd4
   } ic_state_e;

endpackage

// File: rtl/interrupt_controller_priority_enc.sv
// Combinational priority encoder: reports whether any request is set and the
// lowest set index.
module irq_priority_enc
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] i_req,
   output logic               o_valid,
   output logic [IC_ID_W-1:0] o_id
);

   always_comb begin
      o_valid = |i_req;
      o_id    = '0;
      // Walk from the top down so the lowest set bit is the last one written.
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_id = IC_ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: NMI plus NUM_IRQ maskable lines, redirects the CPU at
// instruction boundaries. Define NMI_PREEMPT_EN to let an NMI preempt SERVICE.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned            NUM_IRQ    = 8,
   parameter int unsigned            ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]      VEC_BASE   = ADDR_W'(IC_VEC_BASE),
   parameter int unsigned            VEC_STRIDE = IC_VEC_STRIDE,
   parameter logic [ADDR_W-1:0]      NMI_VEC    = ADDR_W'(IC_NMI_VEC)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NUM_IRQ-1:0]  i_irq,
   input  logic                i_nmi,
   input  logic                i_cpu_busy,
   input  logic                i_instr_boundary,
   input  logic [ADDR_W-1:0]   i_pc_in,
   input  logic                i_mask_we,
   input  logic [NUM_IRQ-1:0]  i_mask_wdata,
   input  logic                i_eret,
   output logic                o_take_irq,
   output logic [ADDR_W-1:0]   o_vector_addr,
   output logic                o_restore_pc,
   output logic [ADDR_W-1:0]   o_epc,
   output logic                o_int_ack,
   output logic [IC_ID_W-1:0]  o_irq_id,
   output ic_state_e           o_state
);

   ic_state_e            r_state;
   ic_state_e            w_next_state;
   logic                 r_nmi_prev;
   logic                 r_nmi_pend;
   logic [NUM_IRQ-1:0]   r_mask;
   logic [ADDR_W-1:0]    r_epc;
   logic [IC_ID_W-1:0]   r_irq_id;
   logic                 r_restore_pc;
   logic                 r_take_nmi;
   logic [IC_ID_W-1:0]   r_take_id;
   logic                 w_nmi_edge;
   logic                 w_enc_valid;
   logic [IC_ID_W-1:0]   w_enc_id;
   logic                 w_req;
   logic                 w_boundary_ok;
   logic                 w_eret_ok;
   logic [ADDR_W-1:0]    w_vec;
`ifdef NMI_PREEMPT_EN
   logic                 r_nested;
   logic                 r_restore_nmi;
   logic [ADDR_W-1:0]    r_epc_nmi;
`endif

   irq_priority_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
      .i_req   (i_irq & r_mask),
      .o_valid (w_enc_valid),
      .o_id    (w_enc_id)
   );

   assign w_nmi_edge    = i_nmi & ~r_nmi_prev;
   assign w_req         = r_nmi_pend | w_enc_valid;
   assign w_boundary_ok = i_instr_boundary & ~i_cpu_busy;
   assign w_eret_ok     = i_eret & ((r_state == ST_SERVICE) | (r_state == ST_NMI_SERVICE));
   assign w_vec         = VEC_BASE + ADDR_W'(r_take_id) * ADDR_W'(VEC_STRIDE);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req) w_next_state = ST_PEND;
         end
         ST_PEND: begin
            if (!w_req)             w_next_state = ST_IDLE;
            else if (w_boundary_ok) w_next_state = ST_TAKE;
         end
         ST_TAKE: begin
            w_next_state = r_take_nmi ? ST_NMI_SERVICE : ST_SERVICE;
         end
         ST_SERVICE: begin
            if (i_eret) w_next_state = ST_IDLE;
`ifdef NMI_PREEMPT_EN
            else if (r_nmi_pend && w_boundary_ok) w_next_state = ST_TAKE;
`endif
         end
         ST_NMI_SERVICE: begin
`ifdef NMI_PREEMPT_EN
            if (i_eret) w_next_state = r_nested ? ST_SERVICE : ST_IDLE;
`else
            if (i_eret) w_next_state = ST_IDLE;
`endif
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_nmi_prev   <= 1'b0;
         r_nmi_pend   <= 1'b0;
         r_mask       <= '1;
         r_epc        <= '0;
         r_irq_id     <= '0;
         r_restore_pc <= 1'b0;
         r_take_nmi   <= 1'b0;
         r_take_id    <= '0;
`ifdef NMI_PREEMPT_EN
         r_nested      <= 1'b0;
         r_restore_nmi <= 1'b0;
         r_epc_nmi     <= '0;
`endif
      end else begin
         r_nmi_prev   <= i_nmi;
         r_restore_pc <= w_eret_ok;
         if (i_mask_we) r_mask <= i_mask_wdata;
         // A fresh edge wins over the clear so back-to-back NMIs are not lost.
         if (w_nmi_edge)                          r_nmi_pend <= 1'b1;
         else if (r_state == ST_TAKE && r_take_nmi) r_nmi_pend <= 1'b0;
         // Freeze the winner at the boundary so TAKE is immune to request changes.
         if (r_state == ST_PEND && w_next_state == ST_TAKE) begin
            r_take_nmi <= r_nmi_pend;
            r_take_id  <= w_enc_id;
         end
`ifdef NMI_PREEMPT_EN
         r_restore_nmi <= w_eret_ok && (r_state == ST_NMI_SERVICE) && r_nested;
         if (r_state == ST_SERVICE && w_next_state == ST_TAKE) begin
            r_take_nmi <= 1'b1;
            r_nested   <= 1'b1;
         end
         if (r_state == ST_TAKE) begin
            if (r_nested) r_epc_nmi <= i_pc_in;
            else          r_epc     <= i_pc_in;
            if (!r_take_nmi) r_irq_id <= r_take_id;
         end
         if (w_eret_ok) begin
            if (r_state == ST_NMI_SERVICE && r_nested) r_nested <= 1'b0;
            else                                      r_irq_id <= '0;
         end
`else
         if (r_state == ST_TAKE) begin
            r_epc <= i_pc_in;
            if (!r_take_nmi) r_irq_id <= r_take_id;
         end
         if (w_eret_ok) r_irq_id <= '0;
`endif
      end
   end

   always_comb begin
      o_take_irq    = (r_state == ST_TAKE);
      o_vector_addr = '0;
      if (r_state == ST_TAKE) o_vector_addr = r_take_nmi ? NMI_VEC : w_vec;
      o_restore_pc  = r_restore_pc;
      o_int_ack     = (r_state == ST_SERVICE) || (r_state == ST_NMI_SERVICE);
      o_irq_id      = r_irq_id;
      o_state       = r_state;
`ifdef NMI_PREEMPT_EN
      // The nested return address stays visible through its restore cycle.
      o_epc = ((r_nested && r_state == ST_NMI_SERVICE) || r_restore_nmi) ? r_epc_nmi : r_epc;
`else
      o_epc = r_epc;
`endif
   end

endmodule
